// File: rtl/pebble_pkg.sv
// Shared types for the Pebble run controller: FSM states and the program-index width
// that the instruction memory and the controller both use.
package pebble_pkg;

   localparam int unsigned PROG_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CRST   = 3'd1,
      ST_START  = 3'd2,
      ST_RUN    = 3'd3,
      ST_REPORT = 3'd4
   } run_state_e;

endpackage

// File: rtl/pebble_cycle_ctr.sv
// Per-program RUN cycle counter: synchronous clear/enable, flags when the count equals LIMIT.
module pebble_cycle_ctr
   import pebble_pkg::*;
#(
   parameter int unsigned CYC_W = 16,
   parameter int unsigned LIMIT = 10000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CYC_W-1:0] count_o,
   output logic             eq_limit_c_o
);

   logic [CYC_W-1:0] cnt_q;
   logic [CYC_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CYC_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o      = cnt_q;
   assign eq_limit_c_o = (cnt_q == CYC_W'(LIMIT));

endmodule

// File: rtl/pebble_run_ctrl.sv
// Run sequencer for the Pebble core: resets, starts and times each program of a range,
// reporting cycle count or timeout per program.
module pebble_run_ctrl
   import pebble_pkg::*;
#(
   parameter int unsigned CYC_W        = 16,
   parameter int unsigned TIMEOUT      = 10000,
   parameter int unsigned RESET_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              go_i,
   input  logic [PROG_W-1:0] prog_first_i,
   input  logic [PROG_W-1:0] prog_last_i,
   input  logic              core_done_i,
   output logic              core_reset_o,
   output logic              core_start_o,
   output logic [PROG_W-1:0] prog_idx_o,
   output logic              busy_o,
   output logic              result_valid_o,
   output logic [PROG_W-1:0] result_prog_o,
   output logic [CYC_W-1:0]  result_cycles_o,
   output logic              result_timeout_o,
   output logic              all_done_o
);

   localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   run_state_e        state_q, state_d;
   logic [RC_W-1:0]   rc_q, rc_d;
   logic [PROG_W-1:0] last_q, last_d;
   logic [PROG_W-1:0] prog_idx_q, prog_idx_d;
   logic              core_reset_q, core_reset_d;
   logic              core_start_q, core_start_d;
   logic              busy_q, busy_d;
   logic              res_valid_q, res_valid_d;
   logic [PROG_W-1:0] res_prog_q, res_prog_d;
   logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;
   logic              res_timeout_q, res_timeout_d;
   logic              all_done_q, all_done_d;
   logic [CYC_W-1:0]  cyc_count;
   logic              cyc_at_limit;

   // Counter is 1 in the first RUN cycle and held at 0 everywhere else
   pebble_cycle_ctr #(
      .CYC_W (CYC_W),
      .LIMIT (TIMEOUT)
   ) u_cycle_ctr (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clr_i        (state_d != ST_RUN),
      .en_i         (state_d == ST_RUN),
      .count_o      (cyc_count),
      .eq_limit_c_o (cyc_at_limit)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (go_i) state_d = ST_CRST;
         ST_CRST:   if (rc_q == '0) state_d = ST_START;
         ST_START:  state_d = ST_RUN;
         ST_RUN:    if (core_done_i || cyc_at_limit) state_d = ST_REPORT;
         ST_REPORT: state_d = (prog_idx_q == last_q) ? ST_IDLE : ST_CRST;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_comb begin
      rc_d          = rc_q;
      last_d        = last_q;
      prog_idx_d    = prog_idx_q;
      res_prog_d    = res_prog_q;
      res_cycles_d  = res_cycles_q;
      res_timeout_d = res_timeout_q;
      all_done_d    = all_done_q;
      core_reset_d  = (state_d == ST_IDLE) || (state_d == ST_CRST);
      core_start_d  = (state_d == ST_START);
      busy_d        = (state_d != ST_IDLE);
      res_valid_d   = (state_d == ST_REPORT);

      if (state_d == ST_CRST && state_q != ST_CRST) begin
         rc_d = RC_W'(RESET_CYCLES - 1);
      end else if (state_q == ST_CRST && rc_q != '0) begin
         rc_d = rc_q - RC_W'(1);
      end

      if (state_q == ST_IDLE && go_i) begin
         last_d     = (prog_last_i < prog_first_i) ? prog_first_i : prog_last_i;
         prog_idx_d = prog_first_i;
         all_done_d = 1'b0;
      end

      if (state_q == ST_RUN && state_d == ST_REPORT) begin
         res_prog_d    = prog_idx_q;
         res_cycles_d  = cyc_count;
         res_timeout_d = !core_done_i;
      end

      if (state_q == ST_REPORT) begin
         if (prog_idx_q == last_q) begin
            all_done_d = 1'b1;
         end else begin
            prog_idx_d = prog_idx_q + PROG_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         rc_q          <= '0;
         last_q        <= '0;
         prog_idx_q    <= '0;
         core_reset_q  <= 1'b1;
         core_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_prog_q    <= '0;
         res_cycles_q  <= '0;
         res_timeout_q <= 1'b0;
         all_done_q    <= 1'b0;
      end else begin
         rc_q          <= rc_d;
         last_q        <= last_d;
         prog_idx_q    <= prog_idx_d;
         core_reset_q  <= core_reset_d;
         core_start_q  <= core_start_d;
         busy_q        <= busy_d;
         res_valid_q   <= res_valid_d;
         res_prog_q    <= res_prog_d;
         res_cycles_q  <= res_cycles_d;
         res_timeout_q <= res_timeout_d;
         all_done_q    <= all_done_d;
      end
   end

   assign core_reset_o     = core_reset_q;
   assign core_start_o     = core_start_q;
   assign prog_idx_o       = prog_idx_q;
   assign busy_o           = busy_q;
   assign result_valid_o   = res_valid_q;
   assign result_prog_o    = res_prog_q;
   assign result_cycles_o  = res_cycles_q;
   assign result_timeout_o = res_timeout_q;
   assign all_done_o       = all_done_q;

endmodule

// File: tb/tb_pebble_run_ctrl.sv
// Bench for pebble_run_ctrl: one instance with default TIMEOUT, one with TIMEOUT=8,
// each driven by a small core model that raises done after a per-program RUN count.
module tb_pebble_run_ctrl;
   import pebble_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]             rst_n, go, core_done, done_frc;
   logic [1:0][1:0]        first, last, prog_idx, res_prog;
   logic [1:0]             core_reset, core_start, busy, res_valid, res_to, all_done;
   logic [1:0][15:0]       res_cyc;

   pebble_run_ctrl u_dut0 (
      .clk_i (clk), .reset_i (rst_n[0]), .go_i (go[0]),
      .prog_first_i (first[0]), .prog_last_i (last[0]), .core_done_i (core_done[0]),
      .core_reset_o (core_reset[0]), .core_start_o (core_start[0]), .prog_idx_o (prog_idx[0]),
      .busy_o (busy[0]), .result_valid_o (res_valid[0]), .result_prog_o (res_prog[0]),
      .result_cycles_o (res_cyc[0]), .result_timeout_o (res_to[0]), .all_done_o (all_done[0])
   );

   pebble_run_ctrl #(.TIMEOUT(8)) u_dut8 (
      .clk_i (clk), .reset_i (rst_n[1]), .go_i (go[1]),
      .prog_first_i (first[1]), .prog_last_i (last[1]), .core_done_i (core_done[1]),
      .core_reset_o (core_reset[1]), .core_start_o (core_start[1]), .prog_idx_o (prog_idx[1]),
      .busy_o (busy[1]), .result_valid_o (res_valid[1]), .result_prog_o (res_prog[1]),
      .result_cycles_o (res_cyc[1]), .result_timeout_o (res_to[1]), .all_done_o (all_done[1])
   );

   typedef struct packed {
      logic        d;
      logic [1:0]  prog;
      logic [15:0] cyc;
      logic        to;
   } res_t;

   typedef struct packed {
      logic            d;
      logic [1:0]      first;
      logic [1:0]      last;
      logic [3:0][7:0] tgt;
      logic [1:0]      nres;
      logic [2:0][1:0] eprog;
      logic [2:0][7:0] ecyc;
      logic [2:0]      eto;
   } vec_t;

   int   tgt [2][4];
   int   rc [2];
   bit   armed [2];
   res_t resq [$];
   int   n_vec = 0;
   int   n_err = 0;

   // Core model: done is raised in the RUN cycle whose index equals the program's target (0 = never)
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (res_valid[g]) begin
            res_t r;
            r.d = 1'(g); r.prog = res_prog[g]; r.cyc = res_cyc[g]; r.to = res_to[g];
            resq.push_back(r);
         end
         if (core_start[g]) begin
            armed[g] = 1'b1;
            rc[g]    = 0;
         end else if (core_reset[g] || !busy[g]) begin
            armed[g] = 1'b0;
         end else if (armed[g]) begin
            rc[g]++;
         end
         core_done[g] = done_frc[g] | (armed[g] && rc[g] != 0 && rc[g] == tgt[g][prog_idx[g]]);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_go(input int d, input int f, input int l);
      first[d] = 2'(f);
      last[d]  = 2'(l);
      go[d]    = 1'b1;
      @(negedge clk);
      go[d]    = 1'b0;
   endtask

   task automatic wait_done(input int d, input int maxc);
      int k = 0;
      while (!all_done[d] && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk("all_done_reached", int'(all_done[d]), 1);
   endtask

   task automatic chk_res(input string nm, input int idx, input int d, input int p, input int c, input int o);
      if (idx < resq.size()) begin
         chk({nm, ".dut"},  int'(resq[idx].d),    d);
         chk({nm, ".prog"}, int'(resq[idx].prog), p);
         chk({nm, ".cyc"},  int'(resq[idx].cyc),  c);
         chk({nm, ".to"},   int'(resq[idx].to),   o);
      end
   endtask

   function automatic vec_t mk(input int d, input int f, input int l,
                               input int t0, input int t1, input int t2, input int t3, input int n,
                               input int p0, input int c0, input int o0,
                               input int p1, input int c1, input int o1,
                               input int p2, input int c2, input int o2);
      vec_t v;
      v.d = 1'(d); v.first = 2'(f); v.last = 2'(l); v.nres = 2'(n);
      v.tgt[0] = 8'(t0); v.tgt[1] = 8'(t1); v.tgt[2] = 8'(t2); v.tgt[3] = 8'(t3);
      v.eprog[0] = 2'(p0); v.ecyc[0] = 8'(c0); v.eto[0] = 1'(o0);
      v.eprog[1] = 2'(p1); v.ecyc[1] = 8'(c1); v.eto[1] = 1'(o1);
      v.eprog[2] = 2'(p2); v.ecyc[2] = 8'(c2); v.eto[2] = 1'(o2);
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      vec_t vecs [7];
      vec_t v;
      int   k;

      // dut, first, last, targets[0..3], nres, then expected (prog, cycles, timeout) x3
      vecs[0] = mk(0, 1, 1,  0, 20, 0, 0, 1,  1, 20, 0,  0, 0, 0,  0, 0, 0);
      vecs[1] = mk(0, 0, 2,  5,  7, 9, 0, 3,  0,  5, 0,  1, 7, 0,  2, 9, 0);
      vecs[2] = mk(1, 0, 1,  0,  3, 0, 0, 2,  0,  8, 1,  1, 3, 0,  0, 0, 0);
      vecs[3] = mk(1, 2, 2,  0,  0, 8, 0, 1,  2,  8, 0,  0, 0, 0,  0, 0, 0);
      vecs[4] = mk(1, 3, 1,  0,  2, 0, 4, 1,  3,  4, 0,  0, 0, 0,  0, 0, 0);
      vecs[5] = mk(1, 2, 3,  0,  0, 7, 0, 2,  2,  7, 0,  3, 8, 1,  0, 0, 0);
      vecs[6] = mk(0, 3, 3,  0,  0, 0, 1, 1,  3,  1, 0,  0, 0, 0,  0, 0, 0);

      rst_n = 2'b00; go = 2'b11; done_frc = 2'b00;
      first = '0; last = '0;

      // Reset held with go high: core stays in reset, nothing reported
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            chk("rst.core_reset", int'(core_reset[g]), 1);
            chk("rst.busy",       int'(busy[g]),       0);
            chk("rst.all_done",   int'(all_done[g]),   0);
            chk("rst.valid",      int'(res_valid[g]),  0);
         end
      end
      go = 2'b00;
      rst_n = 2'b11;
      @(negedge clk);
      chk("rst.no_results", resq.size(), 0);

      // Sequence A: exact CRST/START timing, done ignored in CRST/START, go ignored while busy
      tgt[0] = '{0, 20, 0, 0};
      resq.delete();
      first[0] = 2'd1; last[0] = 2'd1; go[0] = 1'b1; done_frc[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      chk("A.t1.core_reset", int'(core_reset[0]), 1);
      chk("A.t1.core_start", int'(core_start[0]), 0);
      chk("A.t1.busy",       int'(busy[0]),       1);
      chk("A.t1.prog_idx",   int'(prog_idx[0]),   1);
      @(negedge clk);
      chk("A.t2.core_reset", int'(core_reset[0]), 1);
      chk("A.t2.core_start", int'(core_start[0]), 0);
      @(negedge clk);
      chk("A.t3.core_reset", int'(core_reset[0]), 0);
      chk("A.t3.core_start", int'(core_start[0]), 1);
      done_frc[0] = 1'b0;
      @(negedge clk);
      chk("A.run.core_start", int'(core_start[0]), 0);
      chk("A.run.core_reset", int'(core_reset[0]), 0);
      first[0] = 2'd3; last[0] = 2'd3; go[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      k = 1;
      while (!res_valid[0] && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("A.report_latency", k, 20);
      chk("A.res_prog",  int'(res_prog[0]), 1);
      chk("A.res_cyc",   int'(res_cyc[0]),  20);
      chk("A.res_to",    int'(res_to[0]),   0);
      chk("A.rep.all_done", int'(all_done[0]), 0);
      @(negedge clk);
      chk("A.post.all_done", int'(all_done[0]),   1);
      chk("A.post.valid",    int'(res_valid[0]),  0);
      chk("A.post.busy",     int'(busy[0]),       0);
      chk("A.post.res_cyc",  int'(res_cyc[0]),    20);
      chk("A.post.nres",     resq.size(),         1);

      // Table-driven ranges on both instances
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         for (int p = 0; p < 4; p++) tgt[v.d][p] = int'(v.tgt[p]);
         resq.delete();
         pulse_go(int'(v.d), int'(v.first), int'(v.last));
         wait_done(int'(v.d), 300);
         chk($sformatf("v%0d.nres", i), resq.size(), int'(v.nres));
         for (int r = 0; r < int'(v.nres); r++)
            chk_res($sformatf("v%0d.r%0d", i, r), r, int'(v.d),
                    int'(v.eprog[r]), int'(v.ecyc[r]), int'(v.eto[r]));
         chk($sformatf("v%0d.busy", i), int'(busy[v.d]), 0);
         @(negedge clk);
      end

      // Sequence B: reset during RUN of program 1 aborts, then a new go restarts at prog_first
      tgt[0] = '{5, 7, 9, 0};
      resq.delete();
      pulse_go(0, 0, 2);
      k = 0;
      while (!(core_start[0] && prog_idx[0] == 2'd1) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("B.reached_prog1", int'(prog_idx[0]), 1);
      repeat (3) @(negedge clk);
      rst_n[0] = 1'b0;
      resq.delete();
      @(negedge clk);
      chk("B.core_reset", int'(core_reset[0]), 1);
      chk("B.core_start", int'(core_start[0]), 0);
      chk("B.prog_idx",   int'(prog_idx[0]),   0);
      chk("B.busy",       int'(busy[0]),       0);
      chk("B.valid",      int'(res_valid[0]),  0);
      chk("B.res_prog",   int'(res_prog[0]),   0);
      chk("B.res_cyc",    int'(res_cyc[0]),    0);
      chk("B.res_to",     int'(res_to[0]),     0);
      chk("B.all_done",   int'(all_done[0]),   0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      chk("B.no_results", resq.size(), 0);
      pulse_go(0, 1, 2);
      chk("B.restart.prog_idx", int'(prog_idx[0]), 1);
      chk("B.restart.busy",     int'(busy[0]),     1);
      wait_done(0, 300);
      chk("B.restart.nres", resq.size(), 2);
      chk_res("B.r0", 0, 0, 1, 7, 0);
      chk_res("B.r1", 1, 0, 2, 9, 0);
      @(negedge clk);

      // Sequence E: go held high after completion starts the next range on the following edge
      tgt[1] = '{2, 0, 0, 0};
      resq.delete();
      first[1] = 2'd0; last[1] = 2'd0; go[1] = 1'b1;
      @(negedge clk);
      wait_done(1, 100);
      chk("E.idle.busy", int'(busy[1]), 0);
      @(negedge clk);
      go[1] = 1'b0;
      chk("E.restart.busy",       int'(busy[1]),       1);
      chk("E.restart.all_done",   int'(all_done[1]),   0);
      chk("E.restart.core_reset", int'(core_reset[1]), 1);
      wait_done(1, 100);
      chk("E.nres", resq.size(), 2);
      chk_res("E.r1", 1, 1, 0, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
